// File: rtl/sys_defs.sv
// Shared load-buffer / CDB sizing constants and small arbitration helpers.
`ifndef LOAD_BUFFER_SZ
`define LOAD_BUFFER_SZ 8
`endif
`ifndef CDB_SZ
`define CDB_SZ 2
`endif

package sys_defs;

   localparam int unsigned LOAD_BUFFER_SZ = `LOAD_BUFFER_SZ;
   localparam int unsigned CDB_SZ         = `CDB_SZ;
   localparam int unsigned STARVE_LIMIT   = 4;

   typedef logic [$clog2(LOAD_BUFFER_SZ)-1:0] LB_IDX;

   // Distance of idx from start when scanning upward with wrap-around.
   function automatic int unsigned rot_dist(input int unsigned idx,
                                            input int unsigned start,
                                            input int unsigned width);
      return (idx + width - start) % width;
   endfunction

endpackage

// File: rtl/rr_multi_sel.sv
// Rotating-priority multi-grant selector: scans from start upward (mod WIDTH)
// and grants up to limit requesters, reporting them in grant order.
module rr_multi_sel #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned REQS  = 2,
   localparam int unsigned IW    = $clog2(WIDTH),
   localparam int unsigned CW    = $clog2(REQS + 1)
) (
   input  logic [WIDTH-1:0]         req,
   input  logic [IW-1:0]            start,
   input  logic [CW-1:0]            limit,
   output logic [WIDTH-1:0]         gnt,
   output logic [REQS-1:0][IW-1:0]  sel_idx,
   output logic [CW-1:0]            cnt,
   output logic [IW-1:0]            last_idx,
   output logic                     any
);

   logic [IW-1:0] pos;

   // Walk the rotated order once, taking requesters until the limit is hit.
   always_comb begin
      gnt      = '0;
      sel_idx  = '0;
      cnt      = '0;
      last_idx = '0;
      pos      = '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         pos = IW'((32'(start) + k) % WIDTH);
         if (req[pos] && (cnt < limit)) begin
            gnt[pos]     = 1'b1;
            sel_idx[cnt] = pos;
            cnt          = cnt + CW'(1);
            last_idx     = pos;
         end
      end
      any = |gnt;
   end

endmodule

// File: rtl/load_cdb_arbiter.sv
// Load-buffer CDB arbiter: round-robin grants with starvation promotion.
module load_cdb_arbiter #(
   parameter  int unsigned LB_SZ        = sys_defs::LOAD_BUFFER_SZ,
   parameter  int unsigned NUM_CDB      = sys_defs::CDB_SZ,
   parameter  int unsigned STARVE_LIMIT = sys_defs::STARVE_LIMIT,
   localparam int unsigned IW           = $clog2(LB_SZ),
   localparam int unsigned FW           = $clog2(NUM_CDB + 1),
   localparam int unsigned WW           = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [LB_SZ-1:0]            load_cdb_req,
   input  logic [FW-1:0]               cdb_free_cnt,
   output logic [LB_SZ-1:0]            load_cdb_gnt,
   output logic [NUM_CDB-1:0]          port_sel_valid,
   output logic [NUM_CDB-1:0][IW-1:0]  port_sel_idx,
   output logic                        starve_active
);

   logic [IW-1:0]               rr_ptr;
   logic [WW-1:0]               wait_cnt [LB_SZ];
   logic [FW-1:0]               slots;
   logic [FW-1:0]               slots_rest;
   logic [LB_SZ-1:0]            starving;
   logic [LB_SZ-1:0]            gnt_starve;
   logic [LB_SZ-1:0]            gnt_norm;
   logic [LB_SZ-1:0]            gnt_all;
   logic [NUM_CDB-1:0][IW-1:0]  idx_starve;
   logic [NUM_CDB-1:0][IW-1:0]  idx_norm;
   logic [FW-1:0]               cnt_starve;
   logic [FW-1:0]               cnt_norm;
   logic [IW-1:0]               last_starve;
   logic [IW-1:0]               last_norm;
   logic [IW-1:0]               last_gnt;
   logic                        any_starve;
   logic                        any_norm;

   // Clamp free slots to the number of ports loads may use and find starving requesters.
   always_comb begin
      slots    = (cdb_free_cnt > FW'(NUM_CDB)) ? FW'(NUM_CDB) : cdb_free_cnt;
      starving = '0;
      for (int unsigned i = 0; i < LB_SZ; i++)
         starving[i] = load_cdb_req[i] && (wait_cnt[i] == WW'(STARVE_LIMIT));
   end

   rr_multi_sel #(.WIDTH(LB_SZ), .REQS(NUM_CDB)) u_sel_starve (
      .req      (starving),
      .start    (rr_ptr),
      .limit    (slots),
      .gnt      (gnt_starve),
      .sel_idx  (idx_starve),
      .cnt      (cnt_starve),
      .last_idx (last_starve),
      .any      (any_starve)
   );

   assign slots_rest = slots - cnt_starve;

   rr_multi_sel #(.WIDTH(LB_SZ), .REQS(NUM_CDB)) u_sel_norm (
      .req      (load_cdb_req & ~gnt_starve),
      .start    (rr_ptr),
      .limit    (slots_rest),
      .gnt      (gnt_norm),
      .sel_idx  (idx_norm),
      .cnt      (cnt_norm),
      .last_idx (last_norm),
      .any      (any_norm)
   );

   assign gnt_all = gnt_starve | gnt_norm;

   // The pointer must move past whichever grant sits furthest along the scan,
   // which may come from either pass.
   always_comb begin
      last_gnt = last_starve;
      if (any_norm && (!any_starve ||
          sys_defs::rot_dist(32'(last_norm), 32'(rr_ptr), LB_SZ) >
          sys_defs::rot_dist(32'(last_starve), 32'(rr_ptr), LB_SZ)))
         last_gnt = last_norm;
   end

   // Drive outputs: starving grants take the low ports, normal grants follow; all forced low in reset.
   always_comb begin
      load_cdb_gnt   = reset ? gnt_all : '0;
      starve_active  = reset & (|starving);
      port_sel_valid = '0;
      port_sel_idx   = '0;
      for (int unsigned p = 0; p < NUM_CDB; p++) begin
         if (!reset) begin
            port_sel_valid[p] = 1'b0;
         end else if (p < 32'(cnt_starve)) begin
            port_sel_valid[p] = 1'b1;
            port_sel_idx[p]   = idx_starve[p];
         end else if ((p - 32'(cnt_starve)) < 32'(cnt_norm)) begin
            port_sel_valid[p] = 1'b1;
            port_sel_idx[p]   = idx_norm[p - 32'(cnt_starve)];
         end
      end
   end

   // Advance the rotating pointer and age denied requesters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
         for (int unsigned i = 0; i < LB_SZ; i++)
            wait_cnt[i] <= '0;
      end else begin
         if (|gnt_all)
            rr_ptr <= IW'((32'(last_gnt) + 1) % LB_SZ);
         for (int unsigned i = 0; i < LB_SZ; i++) begin
            if (load_cdb_req[i] && !gnt_all[i])
               wait_cnt[i] <= (wait_cnt[i] == WW'(STARVE_LIMIT)) ? wait_cnt[i]
                                                                 : wait_cnt[i] + WW'(1);
            else
               wait_cnt[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_load_cdb_arbiter.sv
// Scoreboard bench for load_cdb_arbiter against a queue-based reference model.
module tb_load_cdb_arbiter;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [7:0]       req   = '0;
   logic [1:0]       free  = '0;
   logic [7:0]       gnt;
   logic [1:0]       pvalid;
   logic [1:0][2:0]  pidx;
   logic             starve;

   load_cdb_arbiter #(.LB_SZ(8), .NUM_CDB(2), .STARVE_LIMIT(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .load_cdb_req   (req),
      .cdb_free_cnt   (free),
      .load_cdb_gnt   (gnt),
      .port_sel_valid (pvalid),
      .port_sel_idx   (pidx),
      .starve_active  (starve)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] gnt;
      logic [1:0] pv;
      logic [2:0] i0;
      logic [2:0] i1;
      logic       st;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: next scan start and consecutive-denial counts.
   int   m_rr;
   int   m_wait[8];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus and queue what the arbiter should present.
   task automatic issue(input logic rst_n, input logic [7:0] r, input logic [1:0] f);
      exp_t e;
      int   slots;
      int   order[$];
      int   starv[$];
      int   rest[$];
      int   picked[$];
      int   maxoff;
      @(posedge clock);
      #1;
      reset = rst_n;
      req   = r;
      free  = f;
      e = '{gnt: '0, pv: '0, i0: '0, i1: '0, st: 1'b0};
      if (!rst_n) begin
         m_rr = 0;
         foreach (m_wait[i]) m_wait[i] = 0;
      end else begin
         slots = (f > 2) ? 2 : int'(f);
         for (int k = 0; k < 8; k++) order.push_back((m_rr + k) % 8);
         foreach (order[j]) begin
            if (r[order[j]] && m_wait[order[j]] == 4) starv.push_back(order[j]);
            else if (r[order[j]]) rest.push_back(order[j]);
         end
         picked = {starv, rest};
         while (picked.size() > slots) void'(picked.pop_back());
         e.st = (starv.size() > 0);
         maxoff = -1;
         foreach (picked[j]) begin
            e.gnt[picked[j]] = 1'b1;
            e.pv[j] = 1'b1;
            if (j == 0) e.i0 = 3'(picked[j]);
            else        e.i1 = 3'(picked[j]);
            if ((picked[j] - m_rr + 8) % 8 > maxoff) maxoff = (picked[j] - m_rr + 8) % 8;
         end
         for (int i = 0; i < 8; i++) begin
            if (r[i] && !e.gnt[i]) m_wait[i] = (m_wait[i] < 4) ? m_wait[i] + 1 : 4;
            else                   m_wait[i] = 0;
         end
         if (maxoff >= 0) m_rr = (m_rr + maxoff + 1) % 8;
      end
      sb.push_back(e);
   endtask

   // Monitor: compare the DUT outputs mid-cycle against the oldest expectation.
   always @(negedge clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("gnt",    gnt,             e.gnt);
         check("valid",  {6'b0, pvalid},  {6'b0, e.pv});
         check("idx0",   {5'b0, pidx[0]}, {5'b0, e.i0});
         check("idx1",   {5'b0, pidx[1]}, {5'b0, e.i1});
         check("starve", {7'b0, starve},  {7'b0, e.st});
      end
   end

   initial begin
      m_rr = 0;
      foreach (m_wait[i]) m_wait[i] = 0;

      // Reset, then idle with no requests.
      repeat (2) issue(1'b0, 8'h00, 2'd0);
      repeat (3) issue(1'b1, 8'h00, 2'd0);

      // Two grants from the pointer upward.
      issue(1'b1, 8'b1011_0110, 2'd2);
      issue(1'b1, 8'b1011_0110, 2'd2);

      // Single-slot rotation through every entry and wrap.
      issue(1'b0, 8'h00, 2'd0);
      repeat (10) issue(1'b1, 8'hFF, 2'd1);

      // Build starvation on idx5, then it must beat idx0.
      issue(1'b0, 8'h00, 2'd0);
      repeat (5) issue(1'b1, 8'h20, 2'd0);
      repeat (2) issue(1'b1, 8'h21, 2'd1);

      // Free count above port count is clamped.
      issue(1'b1, 8'h92, 2'd3);
      issue(1'b1, 8'h07, 2'd3);

      // Reset in the middle of traffic, then restart from idx0.
      repeat (3) issue(1'b1, 8'hFF, 2'd2);
      issue(1'b0, 8'hFF, 2'd2);
      repeat (3) issue(1'b1, 8'hFF, 2'd2);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 600; n++) begin
         logic [7:0] r;
         r = 8'($urandom);
         if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
         issue(($urandom_range(0, 59) != 0), r, 2'($urandom_range(0, 3)));
      end

      // Bounded drain of the scoreboard.
      repeat (3) @(posedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_cdb_arbiter.md
Name: load_cdb_arbiter

Overview:
- Decides which completed load buffer entries drive the CDB each cycle.
- Takes the per-entry load_cdb_req vector from the load buffer and the number of CDB slots left over after the other FUs have been served.
- Returns the same-cycle load_cdb_gnt vector and a per-port entry select that steers the load_result mux onto the CDB.
- Uses rotating (round-robin) priority plus a per-entry starvation counter, so no completed load waits indefinitely.

Parameters:
LB_SZ, `LOAD_BUFFER_SZ (8), number of load buffer entries
NUM_CDB, `CDB_SZ (2), maximum CDB ports loads may use per cycle
STARVE_LIMIT, 4, consecutive denied cycles before an entry is promoted to starving priority

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
load_cdb_req  in  LB_SZ  entry i holds a finished result
cdb_free_cnt  in  $clog2(NUM_CDB+1)  CDB slots available to loads this cycle
load_cdb_gnt  out  LB_SZ  one-hot-per-grant; entry i is written to the CDB this cycle
port_sel_valid  out  NUM_CDB  port p carries a load this cycle
port_sel_idx  out  NUM_CDB x $clog2(LB_SZ)  load buffer index routed to port p
starve_active  out  1  at least one requesting entry is at STARVE_LIMIT

Behaviour:
- All outputs are combinational from inputs and registered state; grants take effect in the same cycle.
- While reset is low, all outputs are 0.
- Registered state: rr_ptr ($clog2(LB_SZ) bits) and wait_cnt[LB_SZ] ($clog2(STARVE_LIMIT+1) bits each).
- Asynchronous reset clears rr_ptr and every wait_cnt to 0.
- Effective slots: slots = min(cdb_free_cnt, NUM_CDB). Values above NUM_CDB are clamped, never an error.
- Starving set: S = req & (wait_cnt == STARVE_LIMIT).
- Grant selection, in two passes:
  - Pass 1 grants from S, scanning indices rr_ptr, rr_ptr+1, ... modulo LB_SZ, until slots are exhausted.
  - Pass 2 grants from req & ~granted, using the same scan order, until slots are exhausted.
- Total grants = min(popcount(req), slots). A grant is never issued to an entry whose req bit is 0.
- Port assignment: grants fill ports 0,1,... in the order they were made (pass 1 first, then scan order).
  - Unused ports have port_sel_valid=0 and port_sel_idx=0.
- rr_ptr update:
  - If any grant was made, rr_ptr <= (index of the last grant in scan order + 1) mod LB_SZ.
  - Otherwise rr_ptr holds.
  - Wrap-around: a last grant at LB_SZ-1 sets rr_ptr to 0.
- wait_cnt[i] update:
  - req[i] & ~gnt[i]: increment, saturating at STARVE_LIMIT.
  - gnt[i] or ~req[i]: cleared to 0. A squashed entry drops its req and so clears its counter.
- slots == 0: no grants, rr_ptr holds, every requesting entry's counter increments.
- starve_active = |S. It is advisory, for issue logic or performance counters.
- More starving entries than slots: they are served by rotating priority within S. rr_ptr advances past those served, so every starving entry is served within ceil(LB_SZ/NUM_CDB) slot-bearing cycles.
- A req falling mid-starvation (branch squash) needs no special handling; the counter clears next edge.
- Reset asserted mid-operation: grants are forced to 0 immediately (asynchronous) and state clears. After release, arbitration restarts at rr_ptr=0.

Decomposition:
- Shared package (sys_defs): `LOAD_BUFFER_SZ, `CDB_SZ, a LB_IDX typedef ($clog2(`LOAD_BUFFER_SZ) bits), and STARVE_LIMIT as a package constant.
- One sub-module: rr_multi_sel (WIDTH, REQS). It takes req and a start pointer and returns up to REQS grants in rotated order, plus the last-granted index.
- The arbiter instantiates it twice, once for the starving pass and once for the normal pass. The normal pass receives REQS reduced by the pass 1 count via a slot-limit input.

Test Plan (LB_SZ=8, NUM_CDB=2, STARVE_LIMIT=4):
1. Reset low, then release with req=0 -> gnt=0, rr_ptr=0, port_sel_valid=00 on every cycle.
2. rr_ptr=0, req=8'b1011_0110, free=2 -> gnt=0000_0110, port0=idx1, port1=idx2; next cycle rr_ptr=3.
3. Hold req=8'b1111_1111, free=1 for 8 cycles -> grants idx0..7 in order, then wrap back to idx0; rr_ptr wraps 7->0.
4. free=0 for 4 cycles with req bit5 set -> wait_cnt[5]=4 and starve_active=1. Then set free=1 with rr_ptr=0 and req=8'b0010_0001 -> gnt=0010_0000 (starving idx5 wins over idx0), and wait_cnt[5] clears.
5. free=3 (above NUM_CDB) and req has 3 bits set -> exactly 2 grants, port_sel_valid=11.
6. Assert reset mid-stream while req=8'hFF, free=2 -> gnt drops to 0 in the same cycle. After release the first grants are idx0 and idx1.
